// File: rtl/uart_tx_bridge_pkg.sv
// Shared definitions for the UART transmit bridge: cursor key codes, the
// escape-sequence bytes they expand into, and the write/read FSM encodings.
package uart_tx_bridge_pkg;

    localparam logic [7:0] KEY_UP         = 8'h80;
    localparam logic [7:0] KEY_DOWN       = 8'h81;
    localparam logic [7:0] KEY_RIGHT      = 8'h82;
    localparam logic [7:0] KEY_LEFT       = 8'h83;
    localparam logic [7:0] ASCII_ESC      = 8'h1B;
    localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
    localparam logic [7:0] ASCII_A        = 8'h41;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ESC1,
        W_ESC2
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_HOLD
    } rd_state_e;

    // Cursor keys occupy 0x80..0x83, so only the low two bits differ.
    function automatic logic is_cursor_key(input logic [7:0] code);
        return code[7:2] == KEY_UP[7:2];
    endfunction

endpackage

// File: rtl/uart_tx_bridge_byte_fifo.sv
// byte_fifo: synchronous FIFO, power-of-two depth, async active-low reset.
// Ports: push/din write, pop read; head is the oldest entry and is valid
// combinationally whenever empty is low; level is the occupancy (0..DEPTH).
// Pushes while full and pops while empty are ignored.
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (do_push && !do_pop)      level_d = level_q + (AW+1)'(1);
        else if (do_pop && !do_push) level_d = level_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by level_q alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_bridge.sv
// uart_tx_bridge: merges keyboard bytes and parser response bytes into one
// FIFO (optionally expanding cursor keys into ESC [ A..D) and drains it to the
// UART transmitter one byte per idle window.
// Ports: key_valid/key_code (pulse, no backpressure), resp_valid/resp_data/
// resp_ready (handshake), tx_busy in, tx_start/tx_data out, fifo_level and
// saturating drop_count status. rst is async active-low.
module uart_tx_bridge
    import uart_tx_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ESC_EXPAND = 1,
    parameter int DROP_W     = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            key_valid,
    input  logic [7:0]                      key_code,
    input  logic                            resp_valid,
    input  logic [7:0]                      resp_data,
    output logic                            resp_ready,
    input  logic                            tx_busy,
    output logic                            tx_start,
    output logic [7:0]                      tx_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [DROP_W-1:0]               drop_count
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    wr_state_e         wr_state_q, wr_state_d;
    rd_state_e         rd_state_q, rd_state_d;
    logic [1:0]        dir_q, dir_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic [7:0]        txd_q, txd_d;

    logic              push, pop, fifo_full, fifo_empty, expand, drop_evt;
    logic [7:0]        din, head;
    logic [LW-1:0]     free_slots, need;

    byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .head  (head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign expand     = (ESC_EXPAND != 0) && is_cursor_key(key_code);
    assign need       = expand ? LW'(3) : LW'(1);
    // Registered level only: a pop in this same cycle earns no credit.
    assign free_slots = LW'(FIFO_DEPTH) - fifo_level;
    // Keys win the write port; a waiting response simply holds.
    assign resp_ready = rst && (wr_state_q == W_IDLE) && !key_valid && !fifo_full;
    assign drop_count = drop_q;

    // Write side: single byte, or the three escape bytes on consecutive cycles.
    always_comb begin
        wr_state_d = wr_state_q;
        dir_d      = dir_q;
        drop_d     = drop_q;
        push       = 1'b0;
        din        = 8'h00;
        drop_evt   = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (key_valid) begin
                    if (free_slots >= need) begin
                        push = 1'b1;
                        if (expand) begin
                            din        = ASCII_ESC;
                            dir_d      = key_code[1:0];
                            wr_state_d = W_ESC1;
                        end else begin
                            din = key_code;
                        end
                    end else begin
                        drop_evt = 1'b1;
                    end
                end else if (resp_valid && resp_ready) begin
                    push = 1'b1;
                    din  = resp_data;
                end
            end
            W_ESC1: begin
                push       = 1'b1;
                din        = ASCII_LBRACKET;
                drop_evt   = key_valid;
                wr_state_d = W_ESC2;
            end
            W_ESC2: begin
                push       = 1'b1;
                din        = ASCII_A + {6'b0, dir_q};
                drop_evt   = key_valid;
                wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
        if (drop_evt && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
    end

    // Read side: start is combinational so tx_data is valid in the start cycle;
    // R_HOLD masks the cycle before the transmitter raises busy.
    always_comb begin
        rd_state_d = rd_state_q;
        txd_d      = txd_q;
        pop        = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    pop        = 1'b1;
                    txd_d      = head;
                    rd_state_d = R_HOLD;
                end
            end
            R_HOLD:  rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    assign tx_start = pop;
    assign tx_data  = txd_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            dir_q      <= 2'b00;
            drop_q     <= '0;
            txd_q      <= 8'h00;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            dir_q      <= dir_d;
            drop_q     <= drop_d;
            txd_q      <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_bridge.sv
module tb_uart_tx_bridge;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       resp_valid = 1'b0;
    logic [7:0] resp_data = 8'h00;
    logic       tx_busy = 1'b0;
    logic       resp_ready, tx_start;
    logic [7:0] tx_data;
    logic [4:0] fifo_level;
    logic [7:0] drop_count;

    uart_tx_bridge #(.FIFO_DEPTH(DEPTH), .ESC_EXPAND(1), .DROP_W(8)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .fifo_level(fifo_level), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: contents of the byte queue, pending escape bytes,
    // drop tally and the byte last handed to the transmitter.
    logic [7:0] mq[$];
    logic [7:0] pend[$];
    int         m_drops = 0;
    bit         m_hold = 0;
    logic [7:0] m_last = 8'h00;
    logic [7:0] sent[$];
    int         n_starts = 0;

    always @(posedge clk or negedge rst) begin : model
        int lvl;
        int need;
        bit do_pop;
        if (!rst) begin
            mq.delete(); pend.delete();
            m_drops = 0; m_hold = 0; m_last = 8'h00;
        end else begin
            lvl    = mq.size();
            do_pop = !m_hold && (lvl > 0) && !tx_busy;
            if (do_pop) begin
                m_last = mq[0];
                void'(mq.pop_front());
            end
            m_hold = do_pop;
            if (pend.size() > 0) begin
                mq.push_back(pend.pop_front());
                if (key_valid && m_drops < 255) m_drops++;
            end else if (key_valid) begin
                need = (key_code >= 8'h80 && key_code <= 8'h83) ? 3 : 1;
                if (DEPTH - lvl >= need) begin
                    if (need == 3) begin
                        mq.push_back(8'h1B);
                        pend.push_back(8'h5B);
                        pend.push_back(8'h41 + key_code - 8'h80);
                    end else begin
                        mq.push_back(key_code);
                    end
                end else if (m_drops < 255) begin
                    m_drops++;
                end
            end else if (resp_valid && lvl < DEPTH) begin
                mq.push_back(resp_data);
            end
        end
    end

    always @(negedge clk) begin : compare
        bit es;
        if (rst) begin
            es = !m_hold && (mq.size() > 0) && !tx_busy;
            chk("tx_start", tx_start, es);
            if (es) chk("tx_data", tx_data, mq[0]);
            else    chk("tx_data_hold", tx_data, m_last);
            chk("fifo_level", fifo_level, mq.size());
            chk("drop_count", drop_count, m_drops);
            chk("resp_ready", resp_ready,
                (pend.size() == 0) && !key_valid && (mq.size() < DEPTH));
            if (tx_start) begin
                sent.push_back(tx_data);
                n_starts++;
            end
        end
    end

    // Transmitter stand-in: either a forced level, or busy for 6 cycles
    // starting the cycle after each start pulse.
    bit bm_en = 0;
    bit busy_force = 0;
    always begin : busy_gen
        int seen;
        int cnt;
        @(posedge clk);
        #1;
        if (bm_en) begin
            if (n_starts != seen) begin
                seen = n_starts;
                cnt  = 6;
            end
            if (cnt > 0) begin
                cnt--;
                tx_busy = 1'b1;
            end else begin
                tx_busy = 1'b0;
            end
        end else begin
            seen    = n_starts;
            cnt     = 0;
            tx_busy = busy_force;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic key(input logic [7:0] c);
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int i;
        for (i = 0; i < 300 && (fifo_level != 0 || tx_busy); i++) tick();
        chk(nm, (i < 300), 1);
    endtask

    initial begin : stim
        int b;
        int hs;
        repeat (3) tick();
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_resp_ready", resp_ready, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drops", drop_count, 0);
        rst = 1'b1;
        tick();

        // Single key, idle transmitter.
        b = sent.size();
        key_valid = 1'b1; key_code = 8'h61;
        @(negedge clk);
        chk("t1_no_start_c0", tx_start, 0);
        tick();
        key_valid = 1'b0;
        @(negedge clk);
        chk("t1_start_c1", tx_start, 1);
        chk("t1_data_c1", tx_data, 8'h61);
        tick();
        @(negedge clk);
        chk("t1_level_empty", fifo_level, 0);
        tick();

        // Cursor up through a busy transmitter.
        bm_en = 1;
        b = sent.size();
        key(8'h80);
        for (int i = 0; i < 200 && sent.size() < b + 3; i++) tick();
        chk("t2_count", sent.size() - b, 3);
        if (sent.size() >= b + 3) begin
            chk("t2_byte0", sent[b],   8'h1B);
            chk("t2_byte1", sent[b+1], 8'h5B);
            chk("t2_byte2", sent[b+2], 8'h41);
        end
        repeat (10) tick();
        bm_en = 0;
        tick();

        // Fill to 14, escape key does not fit, plain key does.
        busy_force = 1;
        tick();
        for (int i = 0; i < 14; i++) key(8'h30 + 8'(i));
        @(negedge clk);
        chk("t3_level14", fifo_level, 14);
        key(8'h81);
        @(negedge clk);
        chk("t3_drop1", drop_count, 1);
        chk("t3_level_still14", fifo_level, 14);
        key(8'h41);
        @(negedge clk);
        chk("t3_level15", fifo_level, 15);
        b = sent.size();
        busy_force = 0;
        drain("t3_drain");
        chk("t3_sent_count", sent.size() - b, 15);
        if (sent.size() >= b + 15) begin
            chk("t3_first", sent[b], 8'h30);
            chk("t3_last", sent[b+14], 8'h41);
        end

        // Key and response in the same cycle: key first, response waits.
        busy_force = 1;
        tick();
        resp_valid = 1'b1; resp_data = 8'h33;
        key_valid = 1'b1; key_code = 8'h62;
        @(negedge clk);
        chk("t4_rr_collision", resp_ready, 0);
        tick();
        key_valid = 1'b0;
        hs = 0;
        for (int i = 0; i < 10 && hs == 0; i++) begin
            @(negedge clk);
            if (resp_ready) hs = 1;
            tick();
        end
        resp_valid = 1'b0;
        chk("t4_handshake", hs, 1);
        @(negedge clk);
        chk("t4_level2", fifo_level, 2);
        b = sent.size();
        busy_force = 0;
        drain("t4_drain");
        chk("t4_sent_count", sent.size() - b, 2);
        if (sent.size() >= b + 2) begin
            chk("t4_order0", sent[b],   8'h62);
            chk("t4_order1", sent[b+1], 8'h33);
        end

        // Key during ESC1 is dropped; reset during ESC2 abandons everything.
        busy_force = 1;
        tick();
        key(8'h82);
        key(8'h61);
        chk("t5_drop2", drop_count, 2);
        chk("t5_level2", fifo_level, 2);
        rst = 1'b0;
        #1;
        chk("t5_rst_level", fifo_level, 0);
        chk("t5_rst_start", tx_start, 0);
        chk("t5_rst_drops", drop_count, 0);
        chk("t5_rst_data", tx_data, 8'h00);
        busy_force = 0;
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Saturating drop counter on a full FIFO.
        busy_force = 1;
        tick();
        for (int i = 0; i < 16; i++) key(8'h61 + 8'(i));
        @(negedge clk);
        chk("t6_full", fifo_level, 16);
        key_valid = 1'b1; key_code = 8'h20;
        repeat (254) tick();
        @(negedge clk);
        chk("t6_drops_fe", drop_count, 8'hFE);
        tick();
        @(negedge clk);
        chk("t6_drops_ff", drop_count, 8'hFF);
        repeat (45) tick();
        key_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_saturated", drop_count, 8'hFF);
        busy_force = 0;
        drain("t6_drain");
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
